gcd_job_arbiter: RTL and testbench

- Shares one GCD engine (the controller/datapath pair) between N_REQ requesters.
- Accepts operand pairs over a per-requester valid/ready handshake and picks one requester round-robin.
- Drives the engine's operands, start pulse and clear pulse, then returns the result on a single response channel tagged with the requester ID.
- Zero operands bypass the engine, because the subtractive engine never terminates on zero.

---
 rtl/gcd_arb_pkg.sv | 20 ++
 rtl/gcd_rr_pick.sv | 32 +++
 rtl/gcd_job_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_gcd_job_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_arb_pkg.sv
// rtl/gcd_arb_pkg.sv - state encoding, default widths and ID-width helper for the GCD job arbiter
package gcd_arb_pkg;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_DW          = 16;
    localparam int DEF_TIMEOUT_CYC = 1023;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_CLR   = 3'd4
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gcd_rr_pick.sv
// rtl/gcd_rr_pick.sv - combinational round-robin picker, searching upward from rr_ptr+1 with wrap
module gcd_rr_pick
    import gcd_arb_pkg::*;
#(
    parameter int  N_REQ = DEF_N_REQ,
    localparam int IDW   = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   rr_ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_idx,
    output logic             any_valid
);

    logic [IDW-1:0] idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = IDW'((int'(rr_ptr) + k) % N_REQ);
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                gnt_idx   = idx;
                gnt[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_job_arbiter.sv
// rtl/gcd_job_arbiter.sv - shares one GCD engine among N_REQ requesters; optional WAIT timeout under GCD_ARB_TIMEOUT_EN
module gcd_job_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int  N_REQ       = DEF_N_REQ,
    parameter int  DW          = DEF_DW,
    parameter int  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int IDW         = id_width(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [IDW-1:0]      resp_id,
    output logic [DW-1:0]       resp_data,
    output logic                resp_err,
    output logic                busy,
    output logic [DW-1:0]       eng_a,
    output logic [DW-1:0]       eng_b,
    output logic                eng_start,
    output logic                eng_clr,
    input  logic                eng_done,
    input  logic [DW-1:0]       eng_result
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [DW-1:0]  resp_data_q, resp_data_d;
    logic [DW-1:0]  eng_a_q, eng_a_d;
    logic [DW-1:0]  eng_b_q, eng_b_d;
    logic           used_eng_q, used_eng_d;

    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             any_valid;
    logic [DW-1:0]    a_arr [N_REQ];
    logic [DW-1:0]    b_arr [N_REQ];
    logic [DW-1:0]    sel_a, sel_b;
    logic             idle;

`ifdef GCD_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          err_q, err_d;
`endif

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DW +: DW];
        assign b_arr[i] = req_b[i*DW +: DW];
    end

    gcd_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .any_valid (any_valid)
    );

    assign sel_a = a_arr[gnt_idx];
    assign sel_b = b_arr[gnt_idx];
    assign idle  = (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        eng_a_d     = eng_a_q;
        eng_b_d     = eng_b_q;
        used_eng_d  = used_eng_q;
`ifdef GCD_ARB_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    rr_ptr_d  = gnt_idx;
                    resp_id_d = gnt_idx;
`ifdef GCD_ARB_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                    // The subtractive engine never terminates on a zero operand, so answer directly.
                    if (sel_a == '0 || sel_b == '0) begin
                        resp_data_d = sel_a | sel_b;
                        used_eng_d  = 1'b0;
                        state_d     = ST_RESP;
                    end else begin
                        eng_a_d    = sel_a;
                        eng_b_d    = sel_b;
                        used_eng_d = 1'b1;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
`ifdef GCD_ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (eng_done) begin
                    resp_data_d = eng_result;
                    state_d     = ST_RESP;
                end
`ifdef GCD_ARB_TIMEOUT_EN
                else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    resp_data_d = '0;
                    err_d       = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = used_eng_q ? ST_CLR : ST_IDLE;
                end
            end
            ST_CLR: begin
                eng_a_d = '0;
                eng_b_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= IDW'(N_REQ - 1);
            resp_id_q   <= '0;
            resp_data_q <= '0;
            eng_a_q     <= '0;
            eng_b_q     <= '0;
            used_eng_q  <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            resp_id_q   <= resp_id_d;
            resp_data_q <= resp_data_d;
            eng_a_q     <= eng_a_d;
            eng_b_q     <= eng_b_d;
            used_eng_q  <= used_eng_d;
`ifdef GCD_ARB_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign req_ready  = (idle && rst_n) ? gnt : '0;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign busy       = !idle;
    assign eng_a      = eng_a_q;
    assign eng_b      = eng_b_q;
    assign eng_start  = (state_q == ST_ISSUE);
    // Holding clear through reset keeps the engine parked while the arbiter restarts.
    assign eng_clr    = (state_q == ST_CLR) || !rst_n;
`ifdef GCD_ARB_TIMEOUT_EN
    assign resp_err   = err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// tb/tb_gcd_job_arbiter.sv - directed self-checking bench for gcd_job_arbiter with a stub engine
module tb_gcd_job_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [1:0]    resp_id;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic          busy;
    logic [DW-1:0] eng_a, eng_b;
    logic          eng_start, eng_clr;
    logic          eng_done;
    logic [DW-1:0] eng_result;

    int n_cmp = 0;
    int n_bad = 0;

    int            m_lat = 2;
    logic          m_hang = 1'b0;
    logic [DW-1:0] m_res = '0;
    logic          m_act = 1'b0;
    logic          m_done = 1'b0;
    int            m_cnt = 0;
    int            start_cnt = 0;
    int            clr_cnt = 0;

    always #5 clk = ~clk;

    gcd_job_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT_CYC(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy),
        .eng_a      (eng_a),
        .eng_b      (eng_b),
        .eng_start  (eng_start),
        .eng_clr    (eng_clr),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    assign eng_done   = m_done;
    assign eng_result = m_done ? m_res : '0;

    always @(posedge clk) begin
        if (eng_start) start_cnt <= start_cnt + 1;
        if (eng_clr && rst_n) clr_cnt <= clr_cnt + 1;
        if (eng_clr) begin
            m_act  <= 1'b0;
            m_done <= 1'b0;
        end else if (eng_start) begin
            m_act <= 1'b1;
            m_cnt <= m_lat;
        end else if (m_act && !m_hang) begin
            if (m_cnt == 0) begin
                m_done <= 1'b1;
                m_act  <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        tick();
        tick();
        n_cmp++;
        if (eng_clr !== 1'b1) begin n_bad++; $display("FAIL reset_eng_clr got %b want 1", eng_clr); end
        n_cmp++;
        if ({resp_valid, busy, eng_start, resp_err, req_ready, resp_id, resp_data, eng_a, eng_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got rv=%b busy=%b st=%b err=%b rdy=%b id=%0d d=%0d a=%0d b=%0d want all 0",
                     resp_valid, busy, eng_start, resp_err, req_ready, resp_id, resp_data, eng_a, eng_b);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (eng_clr !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_idle got clr=%b busy=%b want 0 0", eng_clr, busy);
        end
    endtask

    task automatic test_single_job();
        bit seen;
        int s0, c0;
        s0 = start_cnt;
        c0 = clr_cnt;
        m_lat = 2; m_hang = 1'b0; m_res = 16'd6;
        set_req(0, 16'd48, 16'd18);
        req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        n_cmp++;
        if (eng_start !== 1'b1 || eng_a !== 16'd48 || eng_b !== 16'd18 || busy !== 1'b1) begin
            n_bad++; $display("FAIL single_issue got st=%b a=%0d b=%0d busy=%b want 1 48 18 1", eng_start, eng_a, eng_b, busy);
        end
        tick();
        n_cmp++;
        if (eng_start !== 1'b0) begin n_bad++; $display("FAIL single_start_width got %b want 0", eng_start); end
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (eng_done) seen = 1'b1;
            else tick();
        end
        n_cmp++;
        if (!seen || resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_done seen=%b rv=%b want 1 0", seen, resp_valid);
        end
        tick();
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 16'd6) begin
            n_bad++; $display("FAIL single_resp got rv=%b id=%0d d=%0d want 1 0 6", resp_valid, resp_id, resp_data);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_cmp++;
        if (eng_clr !== 1'b1 || resp_valid !== 1'b0 || eng_a !== 16'd48) begin
            n_bad++; $display("FAIL single_clr got clr=%b rv=%b a=%0d want 1 0 48", eng_clr, resp_valid, eng_a);
        end
        tick();
        n_cmp++;
        if (eng_clr !== 1'b0 || busy !== 1'b0 || eng_a !== 16'd0 || eng_b !== 16'd0) begin
            n_bad++; $display("FAIL single_end got clr=%b busy=%b a=%0d b=%0d want 0 0 0 0", eng_clr, busy, eng_a, eng_b);
        end
        n_cmp++;
        if (start_cnt - s0 !== 1 || clr_cnt - c0 !== 1) begin
            n_bad++; $display("FAIL single_pulses got starts=%0d clrs=%0d want 1 1", start_cnt - s0, clr_cnt - c0);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_rdy;
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 16'd0, DW'(10 + i));
        req_valid = 4'b1111;
        resp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            exp_rdy = '0;
            exp_rdy[order[j]] = 1'b1;
            #1;
            n_cmp++;
            if (req_ready !== exp_rdy) begin n_bad++; $display("FAIL rr_grant%0d got %b want %b", j, req_ready, exp_rdy); end
            tick();
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_id !== 2'(order[j]) || resp_data !== DW'(10 + order[j])) begin
                n_bad++; $display("FAIL rr_resp%0d got rv=%b id=%0d d=%0d want 1 %0d %0d",
                                  j, resp_valid, resp_id, resp_data, order[j], 10 + order[j]);
            end
            tick();
        end
        req_valid = '0;
        resp_ready = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        int s0, c0;
        int ids [3] = '{2, 3, 1};
        logic [DW-1:0] va [3] = '{16'd0, 16'd0, 16'd21};
        logic [DW-1:0] vb [3] = '{16'd35, 16'd0, 16'd0};
        logic [DW-1:0] vr [3] = '{16'd35, 16'd0, 16'd21};
        logic [N-1:0]  onehot;
        s0 = start_cnt;
        c0 = clr_cnt;
        for (int j = 0; j < 3; j++) begin
            set_req(ids[j], va[j], vb[j]);
            onehot = '0;
            onehot[ids[j]] = 1'b1;
            req_valid = onehot;
            #1;
            n_cmp++;
            if (req_ready !== onehot) begin n_bad++; $display("FAIL byp_ready%0d got %b want %b", j, req_ready, onehot); end
            tick();
            req_valid = '0;
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_id !== 2'(ids[j]) || resp_data !== vr[j] || eng_start !== 1'b0) begin
                n_bad++; $display("FAIL byp_resp%0d got rv=%b id=%0d d=%0d st=%b want 1 %0d %0d 0",
                                  j, resp_valid, resp_id, resp_data, eng_start, ids[j], vr[j]);
            end
            resp_ready = 1'b1;
            tick();
            resp_ready = 1'b0;
            n_cmp++;
            if (busy !== 1'b0 || eng_clr !== 1'b0) begin
                n_bad++; $display("FAIL byp_idle%0d got busy=%b clr=%b want 0 0", j, busy, eng_clr);
            end
        end
        n_cmp++;
        if (start_cnt != s0 || clr_cnt != c0) begin
            n_bad++; $display("FAIL byp_no_engine got starts=%0d clrs=%0d want 0 0", start_cnt - s0, clr_cnt - c0);
        end
    endtask

    task automatic test_back_pressure();
        bit ok, seen;
        m_lat = 1; m_hang = 1'b0; m_res = 16'd7;
        set_req(1, 16'd35, 16'd14);
        for (int i = 0; i < N; i++) if (i != 1) set_req(i, 16'd0, 16'd5);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1111;
        ok = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            #1;
            if (resp_valid) seen = 1'b1;
            else begin
                if (req_ready !== '0) ok = 1'b0;
                tick();
            end
        end
        n_cmp++;
        if (!seen || !ok) begin n_bad++; $display("FAIL bp_reach_resp seen=%b ready_quiet=%b want 1 1", seen, ok); end
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 16'd7 || req_ready !== '0) ok = 1'b0;
            tick();
        end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL bp_hold got rv=%b id=%0d d=%0d rdy=%b want 1 1 7 0000", resp_valid, resp_id, resp_data, req_ready); end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_cmp++;
        if (eng_clr !== 1'b1 || req_ready !== '0) begin
            n_bad++; $display("FAIL bp_clr got clr=%b rdy=%b want 1 0000", eng_clr, req_ready);
        end
        tick();
        n_cmp++;
        if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL bp_next_grant got %b want 0100", req_ready); end
        req_valid = '0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_dropped got busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid_wait();
        bit quiet;
        m_hang = 1'b1;
        set_req(3, 16'd9, 16'd6);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b1 || eng_start !== 1'b0) begin n_bad++; $display("FAIL rw_in_wait got busy=%b st=%b want 1 0", busy, eng_start); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (eng_clr !== 1'b1) begin n_bad++; $display("FAIL rw_clr_in_reset got %b want 1", eng_clr); end
        tick();
        rst_n = 1'b1;
        m_hang = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (busy !== 1'b0 || resp_valid !== 1'b0 || eng_a !== 16'd0) quiet = 1'b0;
            tick();
        end
        n_cmp++;
        if (!quiet) begin n_bad++; $display("FAIL rw_abandoned got busy=%b rv=%b a=%0d want 0 0 0", busy, resp_valid, eng_a); end
        set_req(0, 16'd0, 16'd4);
        set_req(3, 16'd0, 16'd8);
        req_valid = 4'b1001;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL rw_first_grant got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== 16'd4) begin
            n_bad++; $display("FAIL rw_resp got rv=%b id=%0d d=%0d want 1 0 4", resp_valid, resp_id, resp_data);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

`ifdef GCD_ARB_TIMEOUT_EN
    task automatic test_timeout();
        m_hang = 1'b1;
        set_req(0, 16'd5, 16'd3);
        req_valid = 4'b0001;
        #1;
        if (req_ready == '0) begin
            set_req(1, 16'd5, 16'd3);
            set_req(2, 16'd5, 16'd3);
            set_req(3, 16'd5, 16'd3);
            req_valid = 4'b1111;
        end
        tick();
        req_valid = '0;
        for (int k = 0; k < 8; k++) tick();
        n_cmp++;
        if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL to_early got rv=%b want 0", resp_valid); end
        tick();
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 16'd0) begin
            n_bad++; $display("FAIL to_resp got rv=%b err=%b d=%0d want 1 1 0", resp_valid, resp_err, resp_data);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_cmp++;
        if (eng_clr !== 1'b1) begin n_bad++; $display("FAIL to_clr got %b want 1", eng_clr); end
        tick();
        m_hang = 1'b0;
        set_req(2, 16'd0, 16'd3);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_data !== 16'd3) begin
            n_bad++; $display("FAIL to_err_clear got rv=%b err=%b d=%0d want 1 0 3", resp_valid, resp_err, resp_data);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_bypass();
        test_back_pressure();
        test_reset_mid_wait();
`ifdef GCD_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
